weight_bank_ctrl: RTL and testbench
===================================

# weight_bank_ctrl

Controller and arbiter for the adaptive filter's tap-weight register bank. It owns TAPS weight registers and shares them between two requesters: the filter read path, which fetches one weight per access, and the LMS adaptation path, which writes one updated weight per access. It also sequences a bulk clear of all taps. The full weight vector is exported continuously for the parallel multiply stage.

## Interface
Parameters:
- TAPS, 8, number of weight registers; any value ≥ 2.
- DATA_W, 16, weight width in bits.
- ADDR_W, $clog2(TAPS), tap address width.

Ports:
- clock, input, 1, single clock; all logic on rising edge.
- reset, input, 1, synchronous, active-high; sampled on rising edge of clock.
- rd_req, input, 1, read request level; held until rd_gnt.
- rd_addr, input, ADDR_W, read tap index; stable while rd_req high.
- rd_gnt, output, 1, one-cycle read grant pulse.
- rd_data, output, DATA_W, read weight; valid in the rd_gnt cycle, holds until next read grant.
- wr_req, input, 1, write request level; held until wr_gnt.
- wr_addr, input, ADDR_W, write tap index.
- wr_data, input, DATA_W, new weight value.
- wr_gnt, output, 1, one-cycle write grant pulse; write committed on the same edge.
- clr_req, input, 1, bulk-clear request level; held until busy is seen.
- busy, output, 1, high while a clear is in progress.
- clr_done, output, 1, one-cycle pulse when the clear completes.
- w_flat, output, TAPS*DATA_W, all weights; tap k at bits [k*DATA_W +: DATA_W].

## Operation
- FSM states: IDLE, GRANT, CLEAR.
- IDLE: evaluates requests each edge. Priority is clr_req, then rd/wr arbitration.
  - clr_req → CLEAR, with clear counter = 0.
  - Otherwise, exactly one of rd_req/wr_req → grant that port and enter GRANT.
- Simultaneous rd_req and wr_req: round-robin. The port not granted last wins.
  - Pointer reset value is "write last", so read wins the first tie.
- Write grant: bank[wr_addr] ← wr_data on the granting edge.
- Read grant: rd_data ← bank[rd_addr] on the granting edge. Pre-edge value applies, so no same-edge write hazard (only one grant per edge).
- GRANT: lasts exactly one cycle, then returns to IDLE. Requests are not sampled in GRANT. Sustained throughput is therefore one access per 2 cycles.
- Requester must drop req in its gnt cycle. A req still high there is a new request, evaluated at the next IDLE edge.
- Address ≥ TAPS: still granted. Write is dropped; read returns 0.
- CLEAR: zeroes one tap per edge, index 0..TAPS-1, with busy high throughout.
  - After tap TAPS-1: clr_done pulses for one cycle, busy falls, and the FSM returns to IDLE.
  - rd/wr requests stall, held pending, and are arbitrated afterwards.
  - clr_req during CLEAR is ignored.
- Arithmetic: none; weights are stored verbatim, with no saturation.

## Timing
- Reset values: rd_gnt 0, wr_gnt 0, rd_data 0, busy 0, clr_done 0, all weights 0 (w_flat 0), state IDLE, RR pointer "write last", clear counter 0.
- Grant latency: request high in cycle n → gnt high in cycle n+1 (registered). w_flat reflects a write from cycle n+1.
- Worst-case access latency with no clear pending: 3 cycles (loses the tie, then waits out the other grant).
- Clear latency: clr_req high in cycle n → busy high cycles n+1..n+TAPS → clr_done high in cycle n+TAPS+1.
- Reset mid-operation (any state): immediate return to reset values on that edge. An aborted clear leaves all weights zero, and no clr_done is produced.

## Configuration
- WEIGHT_BANK_RR_EN defined: round-robin tie-break as above.
- Not defined: fixed priority, write always beats read. The RR pointer is not built. A continuously held wr_req starves reads; this is accepted for adaptation-dominant builds.

## Structure
- Shared package weight_bank_pkg: FSM state encoding (IDLE/GRANT/CLEAR), default TAPS/DATA_W, "last granted" encoding.
- One sub-module: weight_bank_rr_arb, a 2-requester arbiter with pointer update on grant. It is compiled as fixed priority when WEIGHT_BANK_RR_EN is absent.
- Bank storage and the clear counter stay in the top module.

## Test plan
- Reset, then write addr 3 = 16'h1234 → wr_gnt in the next cycle; w_flat tap3 = 16'h1234; read addr 3 → rd_data 16'h1234 with rd_gnt.
- rd_req and wr_req both raised in the same cycle after reset → read granted first, write granted 2 cycles later; both held continuously → grants alternate R,W,R,W (W,W,W… without WEIGHT_BANK_RR_EN).
- Load all taps nonzero, pulse clr_req → busy high for exactly 8 cycles, clr_done the cycle after, w_flat = 0; a wr_req raised during busy is granted right after clr_done.
- clr_req and rd_req raised together → clear takes priority; read granted only after clear completes.
- TAPS=6, write addr 7 = 16'hFFFF → wr_gnt pulses, w_flat unchanged; read addr 7 → rd_data 0.
- Assert reset at clear step 3 → next cycle busy 0, clr_done never pulses, all weights 0, FSM IDLE.

Source files
------------

// File: rtl/weight_bank_pkg.sv
// weight_bank_pkg: shared types and defaults for the tap-weight bank.
// FSM states, "last granted" pointer encoding, default sizes, helpers.
package weight_bank_pkg;

  localparam int DEF_TAPS   = 8;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  typedef enum logic {
    LAST_RD = 1'b0,
    LAST_WR = 1'b1
  } last_t;

  function automatic logic addr_ok(
    input int unsigned addr,
    input int unsigned taps
  );
    return addr < taps;
  endfunction

endpackage

// File: rtl/weight_bank_rr_arb.sv
// weight_bank_rr_arb: two-way read/write arbiter for the weight bank.
// Ports: rd_req/wr_req in, rd_win/wr_win out (combinational winner).
// With WEIGHT_BANK_RR_EN: clock/reset/upd ports and a last-granted
// pointer (reset = write last). Without it: write beats read, no state.
module weight_bank_rr_arb
  import weight_bank_pkg::*;
(
`ifdef WEIGHT_BANK_RR_EN
  input  logic clock,
  input  logic reset,
  input  logic upd,
`endif
  input  logic rd_req,
  input  logic wr_req,
  output logic rd_win,
  output logic wr_win
);

`ifdef WEIGHT_BANK_RR_EN
  last_t last;

  always_comb begin
    rd_win = 1'b0;
    wr_win = 1'b0;
    unique case (1'b1)
      (rd_req && wr_req): begin
        // tie goes to whichever port was not served last
        if (last == LAST_WR) rd_win = 1'b1;
        else                 wr_win = 1'b1;
      end
      (rd_req && !wr_req): rd_win = 1'b1;
      (wr_req && !rd_req): wr_win = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last <= LAST_WR;
    end else if (upd && rd_win) begin
      last <= LAST_RD;
    end else if (upd && wr_win) begin
      last <= LAST_WR;
    end
  end
`else
  assign wr_win = wr_req;
  assign rd_win = rd_req & ~wr_req;
`endif

endmodule

// File: rtl/weight_bank_ctrl.sv
// weight_bank_ctrl: tap-weight bank with read/write arbitration and
// sequenced bulk clear. Ports: clock, reset (sync, active-high);
// rd_req/rd_addr -> rd_gnt/rd_data; wr_req/wr_addr/wr_data -> wr_gnt;
// clr_req -> busy/clr_done; w_flat exports every tap (tap k at
// [k*DATA_W +: DATA_W]). Macro WEIGHT_BANK_RR_EN selects round-robin
// tie-break; otherwise write always wins.
module weight_bank_ctrl
  import weight_bank_pkg::*;
#(
  parameter int TAPS   = DEF_TAPS,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = $clog2(TAPS)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rd_req,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic                   rd_gnt,
  output logic [DATA_W-1:0]      rd_data,
  input  logic                   wr_req,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   wr_gnt,
  input  logic                   clr_req,
  output logic                   busy,
  output logic                   clr_done,
  output logic [TAPS*DATA_W-1:0] w_flat
);

  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(TAPS - 1);

  state_t            state;
  logic [DATA_W-1:0] bank [TAPS];
  logic [ADDR_W-1:0] clr_cnt;
  logic              rd_win;
  logic              wr_win;
  logic              rd_ok;
  logic              wr_ok;

  assign rd_ok = addr_ok(int'(rd_addr), TAPS);
  assign wr_ok = addr_ok(int'(wr_addr), TAPS);

`ifdef WEIGHT_BANK_RR_EN
  // pointer moves only on an edge that actually issues a grant
  logic upd;
  assign upd = (state == S_IDLE) && !clr_req;

  weight_bank_rr_arb u_arb (
    .clock  (clock),
    .reset  (reset),
    .upd    (upd),
    .rd_req (rd_req),
    .wr_req (wr_req),
    .rd_win (rd_win),
    .wr_win (wr_win)
  );
`else
  weight_bank_rr_arb u_arb (
    .rd_req (rd_req),
    .wr_req (wr_req),
    .rd_win (rd_win),
    .wr_win (wr_win)
  );
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      rd_gnt   <= 1'b0;
      wr_gnt   <= 1'b0;
      rd_data  <= '0;
      busy     <= 1'b0;
      clr_done <= 1'b0;
      clr_cnt  <= '0;
      for (int k = 0; k < TAPS; k++) begin
        bank[k] <= '0;
      end
    end else begin
      rd_gnt   <= 1'b0;
      wr_gnt   <= 1'b0;
      clr_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (clr_req) begin
            state   <= S_CLEAR;
            clr_cnt <= '0;
            busy    <= 1'b1;
          end else if (rd_win) begin
            state   <= S_GRANT;
            rd_gnt  <= 1'b1;
            // out-of-range taps read as zero
            rd_data <= rd_ok ? bank[rd_addr] : '0;
          end else if (wr_win) begin
            state  <= S_GRANT;
            wr_gnt <= 1'b1;
            // out-of-range writes are granted but dropped
            if (wr_ok) begin
              bank[wr_addr] <= wr_data;
            end
          end
        end
        // one dead cycle: requests are not looked at here
        S_GRANT: begin
          state <= S_IDLE;
        end
        S_CLEAR: begin
          bank[clr_cnt] <= '0;
          if (clr_cnt == LAST_TAP) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            clr_done <= 1'b1;
            clr_cnt  <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  for (genvar k = 0; k < TAPS; k++) begin : g_flat
    assign w_flat[k*DATA_W +: DATA_W] = bank[k];
  end

endmodule

// File: tb/tb_weight_bank_ctrl.sv
// tb_weight_bank_ctrl: directed bench for weight_bank_ctrl.
// Instantiates an 8-tap and a 6-tap bank on a shared clock/reset.
module tb_weight_bank_ctrl;

  logic         clk;
  logic         reset;

  logic         rd_req, wr_req, clr_req;
  logic [2:0]   rd_addr, wr_addr;
  logic [15:0]  wr_data;
  logic         rd_gnt, wr_gnt, busy, clr_done;
  logic [15:0]  rd_data;
  logic [127:0] w_flat;

  logic         rd_req6, wr_req6, clr_req6;
  logic [2:0]   rd_addr6, wr_addr6;
  logic [15:0]  wr_data6;
  logic         rd_gnt6, wr_gnt6, busy6, clr_done6;
  logic [15:0]  rd_data6;
  logic [95:0]  w_flat6;

  int checks = 0;
  int errors = 0;

  weight_bank_ctrl u8 (
    .clock    (clk),
    .reset    (reset),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_gnt   (rd_gnt),
    .rd_data  (rd_data),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_gnt   (wr_gnt),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_done (clr_done),
    .w_flat   (w_flat)
  );

  weight_bank_ctrl #(.TAPS(6)) u6 (
    .clock    (clk),
    .reset    (reset),
    .rd_req   (rd_req6),
    .rd_addr  (rd_addr6),
    .rd_gnt   (rd_gnt6),
    .rd_data  (rd_data6),
    .wr_req   (wr_req6),
    .wr_addr  (wr_addr6),
    .wr_data  (wr_data6),
    .wr_gnt   (wr_gnt6),
    .clr_req  (clr_req6),
    .busy     (busy6),
    .clr_done (clr_done6),
    .w_flat   (w_flat6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [5:0]   exp_rd, exp_wr;
  logic [127:0] exp_flat;

  initial begin
    reset   = 1'b1;
    rd_req  = 0; wr_req = 0; clr_req = 0;
    rd_addr = 0; wr_addr = 0; wr_data = 0;
    rd_req6 = 0; wr_req6 = 0; clr_req6 = 0;
    rd_addr6 = 0; wr_addr6 = 0; wr_data6 = 0;
    tick();
    tick();
    chk("rst_rd_gnt", rd_gnt, 0);
    chk("rst_wr_gnt", wr_gnt, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_clr_done", clr_done, 0);
    chk("rst_w_flat", w_flat, 0);
    chk("rst_w_flat6", w_flat6, 0);
    reset = 1'b0;
    tick();

    // tie right after reset, both held
`ifdef WEIGHT_BANK_RR_EN
    exp_rd = 6'b010001;
    exp_wr = 6'b000100;
`else
    exp_rd = 6'b000000;
    exp_wr = 6'b010101;
`endif
    rd_req = 1; rd_addr = 0;
    wr_req = 1; wr_addr = 5; wr_data = 16'h55AA;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("tie_rd_gnt%0d", i), rd_gnt, exp_rd[i]);
      chk($sformatf("tie_wr_gnt%0d", i), wr_gnt, exp_wr[i]);
    end
    rd_req = 0; wr_req = 0;
    tick();
    exp_flat = 0;
    exp_flat[5*16 +: 16] = 16'h55AA;
    chk("tie_w_flat", w_flat, exp_flat);

    // write tap 3, then read it back
    wr_req = 1; wr_addr = 3; wr_data = 16'h1234;
    tick();
    chk("wr3_gnt", wr_gnt, 1);
    exp_flat[3*16 +: 16] = 16'h1234;
    chk("wr3_w_flat", w_flat, exp_flat);
    wr_req = 0;
    tick();
    chk("wr3_gnt_drop", wr_gnt, 0);
    rd_req = 1; rd_addr = 3;
    tick();
    chk("rd3_gnt", rd_gnt, 1);
    chk("rd3_data", rd_data, 16'h1234);
    rd_req = 0;
    tick();
    chk("rd3_gnt_drop", rd_gnt, 0);
    chk("rd3_data_hold", rd_data, 16'h1234);

    // load every tap nonzero
    for (int k = 0; k < 8; k++) begin
      wr_req = 1; wr_addr = 3'(k); wr_data = 16'hA000 + 16'(k);
      tick();
      chk($sformatf("load_gnt%0d", k), wr_gnt, 1);
      exp_flat[k*16 +: 16] = 16'hA000 + 16'(k);
      wr_req = 0;
      tick();
    end
    chk("load_w_flat", w_flat, exp_flat);

    // bulk clear with a write arriving while busy
    clr_req = 1;
    tick();
    clr_req = 0;
    wr_req = 1; wr_addr = 2; wr_data = 16'hBEEF;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("clr_busy%0d", i), busy, 1);
      chk($sformatf("clr_done_early%0d", i), clr_done, 0);
      chk($sformatf("clr_wr_stall%0d", i), wr_gnt, 0);
      tick();
    end
    chk("clr_busy_end", busy, 0);
    chk("clr_done", clr_done, 1);
    chk("clr_w_flat", w_flat, 0);
    tick();
    chk("clr_wr_gnt", wr_gnt, 1);
    chk("clr_done_once", clr_done, 0);
    exp_flat = 0;
    exp_flat[2*16 +: 16] = 16'hBEEF;
    chk("clr_wr_w_flat", w_flat, exp_flat);
    wr_req = 0;
    tick();

    // clear and read raised together: clear first
    clr_req = 1; rd_req = 1; rd_addr = 2;
    tick();
    chk("clrrd_busy", busy, 1);
    chk("clrrd_rd_gnt0", rd_gnt, 0);
    clr_req = 0;
    for (int i = 0; i < 8; i++) tick();
    chk("clrrd_done", clr_done, 1);
    chk("clrrd_rd_gnt1", rd_gnt, 0);
    tick();
    chk("clrrd_rd_gnt2", rd_gnt, 1);
    chk("clrrd_rd_data", rd_data, 0);
    rd_req = 0;
    tick();

    // reset during clear step 3
    wr_req = 1; wr_addr = 7; wr_data = 16'h7777;
    tick();
    wr_req = 0;
    tick();
    exp_flat = 0;
    exp_flat[7*16 +: 16] = 16'h7777;
    chk("pre_abort_w_flat", w_flat, exp_flat);
    clr_req = 1;
    tick();
    clr_req = 0;
    tick();
    tick();
    tick();
    chk("abort_busy_pre", busy, 1);
    reset = 1;
    tick();
    reset = 0;
    chk("abort_busy", busy, 0);
    chk("abort_clr_done", clr_done, 0);
    chk("abort_w_flat", w_flat, 0);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("abort_no_done%0d", i), clr_done, 0);
      tick();
    end
    wr_req = 1; wr_addr = 4; wr_data = 16'h4444;
    tick();
    chk("abort_idle_wr_gnt", wr_gnt, 1);
    wr_req = 0;
    tick();

    // six-tap bank: out-of-range address
    wr_req6 = 1; wr_addr6 = 5; wr_data6 = 16'h1111;
    tick();
    wr_req6 = 0;
    tick();
    chk("t6_w5_flat", w_flat6, {16'h1111, 80'h0});
    rd_req6 = 1; rd_addr6 = 5;
    tick();
    chk("t6_rd5_data", rd_data6, 16'h1111);
    rd_req6 = 0;
    tick();
    wr_req6 = 1; wr_addr6 = 7; wr_data6 = 16'hFFFF;
    tick();
    chk("t6_wr7_gnt", wr_gnt6, 1);
    chk("t6_wr7_flat", w_flat6, {16'h1111, 80'h0});
    wr_req6 = 0;
    tick();
    rd_req6 = 1; rd_addr6 = 7;
    tick();
    chk("t6_rd7_gnt", rd_gnt6, 1);
    chk("t6_rd7_data", rd_data6, 0);
    rd_req6 = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
